trailing_one_scanner: RTL
=========================

# trailing_one_scanner

Sequential, parametrised successor to the combinational trailing-one detector. It accepts a DATA_WD-bit vector over a valid/ready handshake and emits the index of every set bit, lowest first, one per output handshake, flagging the final one. It sits between a request-mask producer (e.g. a pending-interrupt or free-slot register) and a consumer that services one index per transfer.

## Interface
- DATA_WD, 8, input vector width; legal range ≥ 2, need not be a power of two
- IND_WD, $clog2(DATA_WD), index width
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_valid  input  1  input vector valid
- o_ready  output  1  block can accept a vector
- i_a  input  DATA_WD  vector to scan
- o_valid  output  1  o_index/o_last/o_empty valid
- i_ready  input  1  consumer accepts current index
- o_index  output  IND_WD  position of lowest remaining set bit
- o_last  output  1  current beat is the final beat of this vector
- o_empty  output  1  accepted vector was all-zero

## Operation
- State: IDLE, SCAN; working register vec[DATA_WD-1:0]; flag empty_q.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_valid&o_ready: vec<=i_a, empty_q<=(i_a==0), go to SCAN.
- SCAN:
  - o_ready=0 (see Configuration), o_valid=1.
  - o_index = binary encode of (vec & -vec).
  - o_last = ((vec & (vec-1))==0).
  - o_empty = empty_q.
  - If empty_q: o_index=0, o_last=1.
- Output handshake is o_valid&i_ready:
  - vec<=vec&(vec-1).
  - If o_last, go to IDLE.
- Backpressure: while o_valid&!i_ready, o_index, o_last and o_empty hold stable and vec is unchanged.
- All-zero input yields exactly one beat: o_index=0, o_empty=1, o_last=1.
- A vector with N set bits (N≥1) yields exactly N beats with strictly increasing indices.
- i_a is sampled only on the input handshake; later changes to i_a are ignored.
- Index encode covers all DATA_WD bits, including non-power-of-two widths; bits ≥ DATA_WD never exist.

## Timing
- Reset (async assert, i_rst_n=0): state=IDLE, vec=0, empty_q=0, o_valid=0, o_index=0, o_last=0, o_empty=0. o_ready reads 1, but no transfer occurs while reset is asserted.
- Reset mid-scan: outputs clear immediately (asynchronously). After release: IDLE, no residual beats.
- Latency: vector accepted at edge k, first o_valid=1 in cycle k+1 (registered).
- Throughput in SCAN: one index per cycle while i_ready=1.
- Vector with N set bits and i_ready held 1:
  - Occupies N cycles in SCAN.
  - Without the macro, next vector accepted no earlier than 1 cycle after the last beat (N+1 cycles per vector).
- Outputs are derived from registered state only; no combinational path from i_a or i_valid to o_valid, o_index, o_last or o_empty.

## Configuration
- TRAILING_ONE_SCANNER_BACK2BACK_EN
  - Defined:
    - o_ready = IDLE | (SCAN & o_last & i_ready).
    - A new vector may be accepted on the same edge as the final output handshake; the block goes directly to SCAN with the new vec and empty_q.
    - Throughput: N cycles per vector, no bubble.
    - o_ready then depends combinationally on i_ready.
  - Undefined: o_ready = IDLE only; one bubble cycle between vectors.

## Test plan
- DATA_WD=8, i_a=8'hA4, i_ready=1 -> beats o_index 2,5,7 on consecutive cycles; o_last=1 only on 7; o_empty=0; then IDLE.
- i_a=8'h00 -> single beat o_index=0, o_empty=1, o_last=1; then o_ready=1.
- i_a=8'h81, i_ready=0 for 3 cycles after o_valid -> o_index=0 held stable for 3 cycles; after i_ready=1: 0 then 7 (o_last).
- Vectors 8'h01 then 8'h80 offered back-to-back, i_ready=1 -> with macro: beats 0,7 in adjacent cycles; without macro: exactly one o_valid=0 cycle between them.
- i_a=8'hFF, drop i_rst_n after the 2nd beat -> o_valid=0 immediately; after release o_ready=1, and no further beats until a new vector is accepted.
- DATA_WD=5, i_a=5'b10000 -> one beat o_index=3'd4, o_last=1; i_a=5'b11111 -> beats 0,1,2,3,4.

Source files
------------

// File: rtl/trailing_one_scanner.sv
// ---------------------------------------------------------------------------
// trailing_one_scanner
//
// Purpose:
//   Accepts a DATA_WD-bit request mask over a valid/ready handshake and then
//   emits the index of every set bit, lowest first, one index per output
//   handshake. The final index of a mask is flagged with o_last. An all-zero
//   mask still produces exactly one beat (index 0, o_empty=1, o_last=1) so the
//   consumer always sees a terminating beat for every accepted mask.
//
// Parameters:
//   DATA_WD  input vector width (>= 2, any value, not just powers of two)
//   IND_WD   index width, defaults to $clog2(DATA_WD)
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  input mask valid
//   o_ready  block can accept a mask this cycle
//   i_a      mask to scan, sampled only on the input handshake
//   o_valid  o_index / o_last / o_empty are valid
//   i_ready  consumer accepts the current index
//   o_index  position of the lowest remaining set bit
//   o_last   current beat is the final beat of this mask
//   o_empty  accepted mask was all-zero
//
// Configuration:
//   TRAILING_ONE_SCANNER_BACK2BACK_EN
//     When defined, a new mask may be accepted on the same edge as the final
//     output handshake of the previous one, removing the idle bubble between
//     masks. o_ready then depends combinationally on i_ready. When undefined,
//     o_ready is asserted only in IDLE.
//
//   All outputs except o_ready (in the back-to-back build) are functions of
//   registered state only; i_a and i_valid never reach o_valid, o_index,
//   o_last or o_empty combinationally.
// ---------------------------------------------------------------------------
module trailing_one_scanner #(
  parameter int DATA_WD = 8,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_a,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_last,
  output logic               o_empty
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DATA_WD-1:0] vec_q;
  logic [DATA_WD-1:0] vec_d;
  logic               empty_q;
  logic               empty_d;

  logic [DATA_WD-1:0] low_bit;
  logic [DATA_WD-1:0] rest_vec;
  logic [IND_WD-1:0]  low_index;
  logic               in_scan;
  logic               scan_last;
  logic               in_fire;
  logic               out_fire;

  // The lowest set bit is isolated with the two's-complement trick
  // (vec & -vec), and the remaining mask after consuming it is vec & (vec-1).
  // When only one bit is left the remainder is zero, which marks the last beat.
  assign low_bit  = vec_q & (~vec_q + DATA_WD'(1));
  assign rest_vec = vec_q & (vec_q - DATA_WD'(1));

  // Binary encode of the isolated one-hot bit. The loop covers exactly
  // DATA_WD positions, so non-power-of-two widths encode correctly and no
  // index at or above DATA_WD can ever appear. With at most one bit set in
  // low_bit, the OR-reduction behaves as a plain one-hot encoder.
  always_comb begin
    low_index = '0;
    for (int i = 0; i < DATA_WD; i++) begin
      if (low_bit[i]) begin
        low_index = low_index | IND_WD'(i);
      end
    end
  end

  // Handshake qualifiers shared by the next-state and output logic. An
  // all-zero mask is forced to be its own last beat so it terminates after a
  // single transfer.
  assign in_scan   = (state_q == ST_SCAN);
  assign scan_last = in_scan & (empty_q | (rest_vec == '0));
  assign in_fire   = i_valid & o_ready;
  assign out_fire  = o_valid & i_ready;

  // State register and working mask. Reset clears everything asynchronously
  // so a scan in progress is abandoned immediately and leaves no residual
  // beats once reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      empty_q <= empty_d;
    end
  end

  // Next-state logic. In IDLE a mask is captured on the input handshake. In
  // SCAN each output handshake clears the lowest set bit; the last handshake
  // returns to IDLE, or in the back-to-back build may load the next mask on
  // the very same edge and stay in SCAN.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    empty_d = empty_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          vec_d   = i_a;
          empty_d = (i_a == '0);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (out_fire) begin
          vec_d = rest_vec;
          if (scan_last) begin
            state_d = ST_IDLE;
`ifdef TRAILING_ONE_SCANNER_BACK2BACK_EN
            if (in_fire) begin
              vec_d   = i_a;
              empty_d = (i_a == '0);
              state_d = ST_SCAN;
            end
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. Beat outputs are gated by SCAN so that IDLE (and reset)
  // always presents zeros regardless of whatever is left in vec_q. An empty
  // mask reports index 0.
  always_comb begin
    o_valid = in_scan;
    o_index = (in_scan && !empty_q) ? low_index : '0;
    o_last  = scan_last;
    o_empty = in_scan & empty_q;
`ifdef TRAILING_ONE_SCANNER_BACK2BACK_EN
    o_ready = (state_q == ST_IDLE) | (scan_last & i_ready);
`else
    o_ready = (state_q == ST_IDLE);
`endif
  end

endmodule
